tournament_bpred: RTL



---
 rtl/datapath_pkg.sv | 29 ++
 rtl/bpred_pht.sv | 44 ++++
 rtl/tournament_bpred.sv | 117 +++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types plus the branch-predictor counter and BTB entry types.
// Counter helpers work on a wide carrier so any CTR_W up to CTR_W_MAX can use them.
package datapath_pkg;

  localparam int DP_WORD_W = 32;
  typedef logic [DP_WORD_W-1:0] word_t;

  localparam int BPRED_CTR_W = 2;
  typedef logic [BPRED_CTR_W-1:0] bpred_ctr_t;
  localparam bpred_ctr_t CTR_WEAK_NT = bpred_ctr_t'((1 << (BPRED_CTR_W - 1)) - 1);

  localparam int CTR_W_MAX = 8;
  typedef logic [CTR_W_MAX-1:0] ctr_wide_t;

  typedef struct packed {
    logic  valid;
    word_t tag;
    word_t target;
  } btb_entry_t;

  function automatic ctr_wide_t sat_inc(input ctr_wide_t v, input ctr_wide_t max_v);
    return (v >= max_v) ? v : v + ctr_wide_t'(1);
  endfunction

  function automatic ctr_wide_t sat_dec(input ctr_wide_t v);
    return (v == '0) ? v : v - ctr_wide_t'(1);
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// Table of saturating counters: one fetch read port, one training read port and
// one saturating-update write port. Reset loads the weakly-not-taken value.
module bpred_pht
  import datapath_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic [IDX_W-1:0] trn_idx_i,
  output logic [CTR_W-1:0] trn_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_inc_i
);

  localparam ctr_wide_t        CTR_MAX   = ctr_wide_t'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0] RESET_VAL = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  ctr_wide_t        upd_cur;
  logic [CTR_W-1:0] upd_d;

  assign rd_ctr_o  = ctr_q[rd_idx_i];
  assign trn_ctr_o = ctr_q[trn_idx_i];

  always_comb begin
    upd_cur = ctr_wide_t'(ctr_q[upd_idx_i]);
    upd_d   = upd_inc_i ? CTR_W'(sat_inc(upd_cur, CTR_MAX)) : CTR_W'(sat_dec(upd_cur));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= RESET_VAL;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_d;
    end
  end

endmodule

// File: rtl/tournament_bpred.sv
// Tournament predictor: bimodal + gshare PHTs picked by a per-PC chooser, gated by a
// direct-mapped BTB. Speculative GHR shifts on BTB hits and is repaired on mispredicts.
module tournament_bpred
  import datapath_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_W       = 6,
  parameter int CTR_W       = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable_fetch,
  input  logic [WORD_W-1:0] pc_fetch,
  output logic [WORD_W-1:0] nxt_pc,
  output logic              pred_taken_fetch,
  output logic              pred_2bit_fetch,
  output logic              pred_gshare_fetch,
  output logic              btb_hit_fetch,
  output logic [GHR_W-1:0]  ghr_fetch,
  input  logic              enable_res,
  input  logic [WORD_W-1:0] pc_res,
  input  logic [WORD_W-1:0] bt_res,
  input  logic              taken_res,
  input  logic              mispredict_res,
  input  logic [GHR_W-1:0]  ghr_res
);

  localparam int PIW   = $clog2(PHT_ENTRIES);
  localparam int BIW   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_W - 2 - BIW;
  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  logic [GHR_W-1:0] ghr_q;
  btb_entry_t       btb_q [BTB_ENTRIES];

  logic [PIW-1:0]   bidx_f, gidx_f, bidx_r, gidx_r;
  logic [BIW-1:0]   btb_idx_f, btb_idx_r;
  logic [TAG_W-1:0] tag_f, tag_r;
  logic [CTR_W-1:0] bim_f, gsh_f, cho_f, bim_r, gsh_r, cho_r;
  btb_entry_t       btb_f, btb_wr_d;
  logic             cho_upd_en, cho_inc, chosen_f;

  assign bidx_f    = pc_fetch[2 +: PIW];
  assign gidx_f    = bidx_f ^ PIW'(ghr_q);
  assign bidx_r    = pc_res[2 +: PIW];
  assign gidx_r    = bidx_r ^ PIW'(ghr_res);
  assign btb_idx_f = pc_fetch[2 +: BIW];
  assign btb_idx_r = pc_res[2 +: BIW];
  assign tag_f     = pc_fetch[WORD_W-1 -: TAG_W];
  assign tag_r     = pc_res[WORD_W-1 -: TAG_W];

  bpred_pht #(.ENTRIES(PHT_ENTRIES), .CTR_W(CTR_W)) u_bim (
    .clk_i(CLK), .rst_i(RST),
    .rd_idx_i(bidx_f), .rd_ctr_o(bim_f),
    .trn_idx_i(bidx_r), .trn_ctr_o(bim_r),
    .upd_en_i(enable_res), .upd_idx_i(bidx_r), .upd_inc_i(taken_res)
  );

  bpred_pht #(.ENTRIES(PHT_ENTRIES), .CTR_W(CTR_W)) u_gsh (
    .clk_i(CLK), .rst_i(RST),
    .rd_idx_i(gidx_f), .rd_ctr_o(gsh_f),
    .trn_idx_i(gidx_r), .trn_ctr_o(gsh_r),
    .upd_en_i(enable_res), .upd_idx_i(gidx_r), .upd_inc_i(taken_res)
  );

  // Chooser only learns when the components disagree, judged on pre-update counters.
  assign cho_upd_en = enable_res && (bim_r[CTR_W-1] != gsh_r[CTR_W-1]);
  assign cho_inc    = (gsh_r[CTR_W-1] == taken_res);

  bpred_pht #(.ENTRIES(PHT_ENTRIES), .CTR_W(CTR_W)) u_cho (
    .clk_i(CLK), .rst_i(RST),
    .rd_idx_i(bidx_f), .rd_ctr_o(cho_f),
    .trn_idx_i(bidx_r), .trn_ctr_o(cho_r),
    .upd_en_i(cho_upd_en), .upd_idx_i(bidx_r), .upd_inc_i(cho_inc)
  );

  assign btb_f             = btb_q[btb_idx_f];
  assign btb_hit_fetch     = btb_f.valid && (btb_f.tag == word_t'(tag_f));
  assign pred_2bit_fetch   = bim_f[CTR_W-1];
  assign pred_gshare_fetch = gsh_f[CTR_W-1];
  assign chosen_f          = cho_f[CTR_W-1] ? pred_gshare_fetch : pred_2bit_fetch;
  assign pred_taken_fetch  = chosen_f && btb_hit_fetch;
  assign nxt_pc            = pred_taken_fetch ? WORD_W'(btb_f.target) : pc_fetch + PC_STEP;
  assign ghr_fetch         = ghr_q;

  // Repair wins over the speculative shift from a same-cycle fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ghr_q <= '0;
    end else if (enable_res && mispredict_res) begin
      ghr_q <= {ghr_res[GHR_W-2:0], taken_res};
    end else if (enable_fetch && btb_hit_fetch) begin
      ghr_q <= {ghr_q[GHR_W-2:0], pred_taken_fetch};
    end
  end

  always_comb begin
    btb_wr_d        = '0;
    btb_wr_d.valid  = 1'b1;
    btb_wr_d.tag    = word_t'(tag_r);
    btb_wr_d.target = word_t'(bt_res);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
    end else if (enable_res && taken_res) begin
      btb_q[btb_idx_r] <= btb_wr_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pc_fetch[1:0], pc_res[1:0], bim_f, gsh_f, cho_f, bim_r, gsh_r, cho_r};

endmodule
